result_pack_stage: RTL and testbench



---
 rtl/result_pack_pkg.sv | 18 +
 rtl/result_fifo.sv | 61 ++++++
 rtl/result_pack_stage.sv | 115 +++++++++++
 tb/tb_result_pack_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_pack_pkg.sv
// Shared types and widths for the result pack stage and its FIFO.
package result_pack_pkg;

   localparam int WORD_W = 16;
   localparam int BEAT_W = 2 * WORD_W;

   typedef enum logic [1:0] {
      PK_IDLE = 2'd0,
      PK_HALF = 2'd1,
      PK_FULL = 2'd2
   } pack_state_e;

   // Even parity of one result word.
   function automatic logic word_par(input logic [WORD_W-1:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Circular word buffer with occupancy count; pushes to a full buffer and pops
// from an empty one are ignored.
module result_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wr_data,
   input  logic                     pop,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign level   = count;
   assign rd_data = mem[rd_ptr];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= wr_data;
   end

   // Pointers are AW bits wide, so wrap modulo DEPTH falls out naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/result_pack_stage.sv
// Buffers 16-bit result words and packs pairs into 32-bit valid/ready beats;
// flush drains an odd word as a zero-padded last beat. RESULT_PACK_PARITY_EN adds out_par.
//
// state   | meaning
// PK_IDLE | no half word held; next FIFO word becomes lo
// PK_HALF | lo held; waiting for hi word or pending flush
// PK_FULL | beat presented on out_*; waiting for out_ready
module result_pack_stage
   import result_pack_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = WORD_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_data,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*W-1:0]           out_data,
   output logic                     out_last,
   output logic [$clog2(DEPTH):0]   level
`ifdef RESULT_PACK_PARITY_EN
   ,
   output logic [1:0]               out_par
`endif
);

   pack_state_e state;
   logic [W-1:0] lo;
   logic [W-1:0] fifo_rd_data;
   logic         fifo_full;
   logic         fifo_empty;
   logic         fifo_push;
   logic         fifo_pop;
   logic         flush_pend;

   // Acceptance depends only on registered occupancy, never on out_ready.
   assign in_ready  = !rst && !fifo_full;
   assign fifo_push = in_valid && in_ready;
   assign fifo_pop  = !fifo_empty && ((state == PK_IDLE) || (state == PK_HALF));

   result_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .wr_data (in_data),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= PK_IDLE;
         lo         <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         flush_pend <= 1'b0;
`ifdef RESULT_PACK_PARITY_EN
         out_par    <= 2'b00;
`endif
      end else begin
         // Later clears in the case below take precedence over a same-cycle flush.
         if (flush)
            flush_pend <= 1'b1;
         case (state)
            PK_IDLE: begin
               if (!fifo_empty) begin
                  lo    <= fifo_rd_data;
                  state <= PK_HALF;
               end else if (flush_pend) begin
                  flush_pend <= 1'b0;
               end
            end
            PK_HALF: begin
               if (!fifo_empty) begin
                  out_data  <= {fifo_rd_data, lo};
                  out_last  <= 1'b0;
                  out_valid <= 1'b1;
`ifdef RESULT_PACK_PARITY_EN
                  out_par   <= {^fifo_rd_data, ^lo};
`endif
                  state     <= PK_FULL;
               end else if (flush_pend) begin
                  out_data   <= {{W{1'b0}}, lo};
                  out_last   <= 1'b1;
                  out_valid  <= 1'b1;
                  flush_pend <= 1'b0;
`ifdef RESULT_PACK_PARITY_EN
                  out_par    <= {1'b0, ^lo};
`endif
                  state      <= PK_FULL;
               end
            end
            PK_FULL: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= PK_IDLE;
               end
            end
            default: state <= PK_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_pack_stage.sv
// Directed self-checking bench for result_pack_stage (DEPTH=4, W=16).
module tb_result_pack_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic [2:0]  level;
`ifdef RESULT_PACK_PARITY_EN
   logic [1:0]  out_par;
`endif

   int passed = 0;
   int total  = 0;

   result_pack_stage #(.DEPTH(4), .W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .level     (level)
`ifdef RESULT_PACK_PARITY_EN
      ,
      .out_par   (out_par)
`endif
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push1(input logic [15:0] d);
      in_valid = 1'b1;
      in_data  = d;
      cyc();
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for a beat with out_ready high, check it, then take the handshake.
   task automatic expect_beat(input string tag, input logic [31:0] d, input logic l);
      int n = 0;
      out_ready = 1'b1;
      while (!out_valid && n < 20) begin
         cyc();
         n++;
      end
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_data"},  64'(out_data),  64'(d));
      chk({tag, "_last"},  64'(out_last),  64'(l));
`ifdef RESULT_PACK_PARITY_EN
      chk({tag, "_par"},   64'(out_par),   64'({^d[31:16], ^d[15:0]}));
`endif
      cyc();
   endtask

   // Push 0x1111, 0x2222, ... every cycle for 10 cycles; return how many were accepted.
   task automatic fill(output int acc);
      logic take;
      acc      = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 16'(32'h1111 * (acc + 1));
         take    = in_ready;
         cyc();
         if (take) acc++;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int acc;
      int n;
      logic [31:0] held_data;
      logic        held_last;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_in_ready",  64'(in_ready),  64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_out_last",  64'(out_last),  64'd0);
      chk("rst_level",     64'(level),     64'd0);
      cyc();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Pair, no stall: words in cycles 0 and 1, beat visible in cycle 3.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h0001;
      cyc();
      in_data   = 16'h00FF;
      cyc();
      in_valid  = 1'b0;
      chk("pair_c2_valid", 64'(out_valid), 64'd0);
      cyc();
      chk("pair_c3_valid", 64'(out_valid), 64'd1);
      chk("pair_data",     64'(out_data),  64'h00FF0001);
      chk("pair_last",     64'(out_last),  64'd0);
`ifdef RESULT_PACK_PARITY_EN
      chk("pair_par",      64'(out_par),   64'b01);
`endif
      cyc();
      chk("pair_done_valid", 64'(out_valid), 64'd0);
      chk("pair_done_level", 64'(level),     64'd0);

      // Full stall: DEPTH + 2 words before in_ready drops.
      out_ready = 1'b0;
      fill(acc);
      chk("stall_accepts",  64'(acc),      64'd6);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_level",    64'(level),    64'd4);
      expect_beat("stall_b0", 32'h22221111, 1'b0);
      expect_beat("stall_b1", 32'h44443333, 1'b0);
      expect_beat("stall_b2", 32'h66665555, 1'b0);
      chk("stall_drained", 64'(level), 64'd0);

      // Odd flush then a normal pair.
      push1(16'hABCD);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      expect_beat("odd_flush", 32'h0000ABCD, 1'b1);
      push1(16'h1234);
      push1(16'h5678);
      expect_beat("after_flush", 32'h56781234, 1'b0);

      // Empty flush: nothing emitted, and it must not linger for the next word.
      for (int i = 0; i < 3; i++) cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("empty_flush_novalid", 64'(out_valid), 64'd0);
      end
      push1(16'h0BAD);
      for (int i = 0; i < 6; i++) cyc();
      chk("held_novalid", 64'(out_valid), 64'd0);
      chk("held_level",   64'(level),     64'd0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      expect_beat("held_flush", 32'h00000BAD, 1'b1);

      // Back-pressure hold.
      out_ready = 1'b0;
      push1(16'hC001);
      push1(16'hC002);
      n = 0;
      while (!out_valid && n < 20) begin
         cyc();
         n++;
      end
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data",  64'(out_data),  64'hC002C001);
      held_data = 32'hC002C001;
      held_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_hold_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_data",  64'(out_data),  64'(held_data));
         chk("bp_hold_last",  64'(out_last),  64'(held_last));
      end
      out_ready = 1'b1;
      cyc();
      for (int i = 0; i < 4; i++) begin
         chk("bp_one_handshake", 64'(out_valid), 64'd0);
         cyc();
      end

      // Reset mid-op with level 3 in PK_HALF.
      out_ready = 1'b0;
      fill(acc);
      chk("rst_fill_accepts", 64'(acc), 64'd6);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      cyc();
      chk("mid_level",  64'(level),     64'd3);
      chk("mid_valid",  64'(out_valid), 64'd0);
      chk("mid_data",   64'(out_data),  64'h22221111);
      rst = 1'b1;
      #1;
      chk("async_rst_valid",    64'(out_valid), 64'd0);
      chk("async_rst_data",     64'(out_data),  64'd0);
      chk("async_rst_level",    64'(level),     64'd0);
      chk("async_rst_in_ready", 64'(in_ready),  64'd0);
      rst = 1'b0;
      cyc();
      out_ready = 1'b1;
      push1(16'h0005);
      push1(16'h0006);
      expect_beat("fresh_pair", 32'h00060005, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("fresh_no_stale", 64'(out_valid), 64'd0);
      end
      chk("fresh_level", 64'(level), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
